// File: rtl/adma_axi_mem_slv_if.sv
// AXI4 AR/R/AW/W/B channel bundle between the DMA data mover (master) and its memory responder (slave).
interface adma_axi_mem_slv_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int ID_W   = 5,
  parameter int LEN_W  = 8,
  parameter int RESP_W = 2
);
  logic [ID_W-1:0]   s_arid_i;
  logic [ADDR_W-1:0] s_araddr_i;
  logic [LEN_W-1:0]  s_arlen_i;
  logic [1:0]        s_arburst_i;
  logic              s_arvalid_i;
  logic              s_arready_o;
  logic [ID_W-1:0]   s_rid_o;
  logic [DATA_W-1:0] s_rdata_o;
  logic [RESP_W-1:0] s_rresp_o;
  logic              s_rlast_o;
  logic              s_rvalid_o;
  logic              s_rready_i;
  logic [ID_W-1:0]   s_awid_i;
  logic [ADDR_W-1:0] s_awaddr_i;
  logic [LEN_W-1:0]  s_awlen_i;
  logic [1:0]        s_awburst_i;
  logic              s_awvalid_i;
  logic              s_awready_o;
  logic [DATA_W-1:0] s_wdata_i;
  logic              s_wlast_i;
  logic              s_wvalid_i;
  logic              s_wready_o;
  logic [ID_W-1:0]   s_bid_o;
  logic [RESP_W-1:0] s_bresp_o;
  logic              s_bvalid_o;
  logic              s_bready_i;

  modport slave (
    input  s_arid_i, s_araddr_i, s_arlen_i, s_arburst_i, s_arvalid_i, s_rready_i,
    input  s_awid_i, s_awaddr_i, s_awlen_i, s_awburst_i, s_awvalid_i,
    input  s_wdata_i, s_wlast_i, s_wvalid_i, s_bready_i,
    output s_arready_o, s_rid_o, s_rdata_o, s_rresp_o, s_rlast_o, s_rvalid_o,
    output s_awready_o, s_wready_o, s_bid_o, s_bresp_o, s_bvalid_o
  );

  modport master (
    output s_arid_i, s_araddr_i, s_arlen_i, s_arburst_i, s_arvalid_i, s_rready_i,
    output s_awid_i, s_awaddr_i, s_awlen_i, s_awburst_i, s_awvalid_i,
    output s_wdata_i, s_wlast_i, s_wvalid_i, s_bready_i,
    input  s_arready_o, s_rid_o, s_rdata_o, s_rresp_o, s_rlast_o, s_rvalid_o,
    input  s_awready_o, s_wready_o, s_bid_o, s_bresp_o, s_bvalid_o
  );
endinterface

// File: rtl/adma_axi_mem_slv.sv
// AXI4 full-width-beat memory responder with independent read and write FSMs.
// Define ADMA_MEM_SLV_AR_FIFO_EN to queue up to AR_OSTD read requests in order.
module adma_axi_mem_slv #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 256,
  parameter int MST_ID_W   = 5,
  parameter int ATX_LEN_W  = 8,
  parameter int ATX_RESP_W = 2,
  parameter int MEM_DEPTH  = 1024,
  parameter int AR_OSTD    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  adma_axi_mem_slv_if.slave s
);
  localparam int BYTE_AMT = DATA_W / 8;
  localparam int OFF_W    = $clog2(BYTE_AMT);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [ATX_RESP_W-1:0] RESP_OK  = ATX_RESP_W'(0);
  localparam logic [ATX_RESP_W-1:0] RESP_SLV = ATX_RESP_W'(2);

  typedef struct packed {
    logic [MST_ID_W-1:0]  id;
    logic [ADDR_W-1:0]    addr;
    logic [ATX_LEN_W-1:0] len;
    logic [1:0]           burst;
  } ar_req_t;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic beat_err(input logic [ADDR_W-1:0] a, input logic [1:0] b);
    return b[1] | ((a >> OFF_W) >= ADDR_W'(MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] widx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

  function automatic logic [ADDR_W-1:0] step(input logic [1:0] b);
    return (b == 2'b01) ? ADDR_W'(BYTE_AMT) : '0;
  endfunction

  // Keeps the readies low while reset is held and for the first cycle after release.
  logic run;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;

  // ---------------- read side ----------------
  r_state_t r_state, r_nxt;
  ar_req_t  ar_in, head;
  logic     head_vld, can_take, take, r_hs, ld;

  logic [MST_ID_W-1:0]   rid;
  logic [DATA_W-1:0]     rdata;
  logic [ATX_RESP_W-1:0] rresp;
  logic                  rlast, rvalid;
  logic [ADDR_W-1:0]     raddr;
  logic [ATX_LEN_W-1:0]  rlen, rbeat;
  logic [1:0]            rburst;

  assign ar_in = '{id: s.s_arid_i, addr: s.s_araddr_i, len: s.s_arlen_i, burst: s.s_arburst_i};
  assign r_hs  = rvalid & s.s_rready_i;

`ifdef ADMA_MEM_SLV_AR_FIFO_EN
  localparam int PTR_W = (AR_OSTD > 1) ? $clog2(AR_OSTD) : 1;
  ar_req_t          fifo_q [AR_OSTD];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             empty, full, push, pop;

  assign empty         = (cnt == '0);
  assign full          = (cnt == (PTR_W+1)'(AR_OSTD));
  assign s.s_arready_o = run & !full;
  assign can_take      = (r_state == R_IDLE) | (r_hs & rlast);
  // An AR arriving at an empty queue in a pop cycle goes straight to the read FSM.
  assign head_vld      = !empty | (s.s_arvalid_i & run);
  assign head          = empty ? ar_in : fifo_q[rd_ptr];
  assign push          = s.s_arvalid_i & s.s_arready_o & !(empty & take);
  assign pop           = take & !empty;

  always_ff @(posedge clk)
    if (push) fifo_q[wr_ptr] <= ar_in;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(AR_OSTD-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(AR_OSTD-1)) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
`else
  assign s.s_arready_o = run & (r_state == R_IDLE);
  assign can_take      = (r_state == R_IDLE);
  assign head_vld      = s.s_arvalid_i & run;
  assign head          = ar_in;
`endif

  assign take = can_take & head_vld;
  assign ld   = take | (r_hs & !rlast);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_nxt;

  always_comb begin
    r_nxt = r_state;
    case (r_state)
      R_IDLE:  if (take) r_nxt = R_DATA;
      R_DATA:  if (r_hs && rlast && !take) r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end

  // One beat is loaded per cycle, either the first of a new burst or the next of the current one.
  logic [ADDR_W-1:0]    ld_addr;
  logic [1:0]           ld_burst;
  logic [ATX_LEN_W-1:0] ld_len, ld_beat;
  logic                 ld_err;

  assign ld_addr  = take ? head.addr  : raddr;
  assign ld_burst = take ? head.burst : rburst;
  assign ld_len   = take ? head.len   : rlen;
  assign ld_beat  = take ? '0         : rbeat;
  assign ld_err   = beat_err(ld_addr, ld_burst);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rid    <= '0;
      rdata  <= '0;
      rresp  <= RESP_OK;
      rlast  <= 1'b0;
      rvalid <= 1'b0;
      raddr  <= '0;
      rlen   <= '0;
      rbeat  <= '0;
      rburst <= '0;
    end else if (ld) begin
      rvalid <= 1'b1;
      rdata  <= ld_err ? '0 : mem[widx(ld_addr)];
      rresp  <= ld_err ? RESP_SLV : RESP_OK;
      rlast  <= (ld_beat == ld_len);
      raddr  <= ld_addr + step(ld_burst);
      rbeat  <= ld_beat + 1'b1;
      if (take) begin
        rid    <= head.id;
        rlen   <= head.len;
        rburst <= head.burst;
      end
    end else if (r_hs) begin
      rvalid <= 1'b0;
    end

  assign s.s_rid_o    = rid;
  assign s.s_rdata_o  = rdata;
  assign s.s_rresp_o  = rresp;
  assign s.s_rlast_o  = rlast;
  assign s.s_rvalid_o = rvalid;

  // ---------------- write side ----------------
  w_state_t w_state, w_nxt;
  logic [MST_ID_W-1:0]   wid;
  logic [ADDR_W-1:0]     waddr;
  logic [ATX_LEN_W-1:0]  wlen, wbeat;
  logic [1:0]            wburst;
  logic                  werr;
  logic [ATX_RESP_W-1:0] bresp;
  logic                  aw_hs, w_hs, w_end, w_done, w_berr, bad_last, mem_we;

  assign s.s_awready_o = run & (w_state == W_IDLE);
  assign s.s_wready_o  = (w_state == W_DATA);
  assign s.s_bvalid_o  = (w_state == W_RESP);
  assign s.s_bid_o     = wid;
  assign s.s_bresp_o   = bresp;

  assign aw_hs    = s.s_awvalid_i & s.s_awready_o;
  assign w_hs     = s.s_wvalid_i & s.s_wready_o;
  assign w_end    = (wbeat == wlen);
  assign w_done   = w_hs & (s.s_wlast_i | w_end);
  assign w_berr   = beat_err(waddr, wburst);
  // wlast arriving early, or missing on beat LEN, both make the burst an error.
  assign bad_last = s.s_wlast_i ^ w_end;
  assign mem_we   = w_hs & !w_berr;

  always_ff @(posedge clk)
    if (mem_we) mem[widx(waddr)] <= s.s_wdata_i;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_nxt;

  always_comb begin
    w_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_nxt = W_DATA;
      W_DATA:  if (w_done) w_nxt = W_RESP;
      W_RESP:  if (s.s_bready_i) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wid    <= '0;
      waddr  <= '0;
      wlen   <= '0;
      wbeat  <= '0;
      wburst <= '0;
      werr   <= 1'b0;
      bresp  <= RESP_OK;
    end else if (aw_hs) begin
      wid    <= s.s_awid_i;
      waddr  <= s.s_awaddr_i;
      wlen   <= s.s_awlen_i;
      wburst <= s.s_awburst_i;
      wbeat  <= '0;
      werr   <= 1'b0;
    end else if (w_hs) begin
      waddr <= waddr + step(wburst);
      wbeat <= wbeat + 1'b1;
      werr  <= werr | w_berr | bad_last;
      if (w_done) bresp <= (werr | w_berr | bad_last) ? RESP_SLV : RESP_OK;
    end
endmodule
